// File: rtl/bcd_mod_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_mod_counter_if : control, load and result signals of bcd_mod_counter     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface bcd_mod_counter_if;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_units;
  logic [3:0] tens;
  logic [3:0] units;
  logic       tc;
  logic       load_err;

  modport master (
    output en, up_dn, clr, load, load_tens, load_units,
    input  tens, units, tc, load_err
  );

  modport slave (
    input  en, up_dn, clr, load, load_tens, load_units,
    output tens, units, tc, load_err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_mod_counter : two-digit packed-BCD up/down modulo counter with         |
// | prescaler, clear, checked parallel load and terminal-count pulse           |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module bcd_mod_counter #(
  parameter int MAX_VAL  = 59,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               reset,
  bcd_mod_counter_if.slave   bus
);

  localparam int                c_PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PS_W-1:0] c_PS_LAST   = c_PS_W'(PRESCALE - 1);
  localparam logic [3:0]        c_MAX_TENS  = 4'(MAX_VAL / 10);
  localparam logic [3:0]        c_MAX_UNITS = 4'(MAX_VAL % 10);
  localparam logic [7:0]        c_MAX_BIN   = 8'(MAX_VAL);

  logic [3:0]        r_tens;
  logic [3:0]        r_units;
  logic              r_tc;
  logic              r_load_err;
  logic [c_PS_W-1:0] r_presc;

  logic [7:0] w_load_bin;
  logic [7:0] w_cur_bin;
  logic       w_load_ok;
  logic       w_illegal;
  logic       w_step;
  logic [3:0] w_nxt_tens;
  logic [3:0] w_nxt_units;
  logic       w_wrap;

  // Binary weights only feed comparators; the stored value stays BCD.
  assign w_load_bin = 8'(bus.load_tens) * 8'd10 + 8'(bus.load_units);
  assign w_cur_bin  = 8'(r_tens) * 8'd10 + 8'(r_units);
  assign w_load_ok  = (bus.load_tens <= 4'd9) && (bus.load_units <= 4'd9) &&
                      (w_load_bin <= c_MAX_BIN);
  assign w_illegal  = (r_tens > 4'd9) || (r_units > 4'd9) || (w_cur_bin > c_MAX_BIN);
  assign w_step     = bus.en && (r_presc == c_PS_LAST);

  always_comb begin
    w_nxt_tens  = 4'd0;
    w_nxt_units = 4'd0;
    w_wrap      = 1'b0;
    if (w_illegal) begin
      w_nxt_tens  = 4'd0;
      w_nxt_units = 4'd0;
    end else if (bus.up_dn) begin
      if (w_cur_bin == c_MAX_BIN) begin
        w_wrap = 1'b1;
      end else if (r_units == 4'd9) begin
        w_nxt_tens  = r_tens + 4'd1;
      end else begin
        w_nxt_tens  = r_tens;
        w_nxt_units = r_units + 4'd1;
      end
    end else begin
      if (w_cur_bin == 8'd0) begin
        w_nxt_tens  = c_MAX_TENS;
        w_nxt_units = c_MAX_UNITS;
        w_wrap      = 1'b1;
      end else if (r_units != 4'd0) begin
        w_nxt_tens  = r_tens;
        w_nxt_units = r_units - 4'd1;
      end else begin
        w_nxt_tens  = r_tens - 4'd1;
        w_nxt_units = 4'd9;
      end
    end
  end

  // Pulses default low every edge so tc and load_err last exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tens     <= 4'd0;
      r_units    <= 4'd0;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
      r_presc    <= '0;
    end else begin
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
      if (bus.clr) begin
        r_tens  <= 4'd0;
        r_units <= 4'd0;
        r_presc <= '0;
      end else if (bus.load) begin
        if (w_load_ok) begin
          r_tens  <= bus.load_tens;
          r_units <= bus.load_units;
          r_presc <= '0;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (bus.en) begin
        if (w_step) begin
          r_presc <= '0;
          r_tens  <= w_nxt_tens;
          r_units <= w_nxt_units;
          r_tc    <= w_wrap;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign bus.tens     = r_tens;
  assign bus.units    = r_units;
  assign bus.tc       = r_tc;
  assign bus.load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bcd_mod_counter : directed self-checking bench for bcd_mod_counter      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bcd_mod_counter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  bcd_mod_counter_if ifa ();  // MAX_VAL 59, PRESCALE 1
  bcd_mod_counter_if ifb ();  // MAX_VAL 59, PRESCALE 3
  bcd_mod_counter_if ifc ();  // MAX_VAL 23, PRESCALE 1

  bcd_mod_counter #(.MAX_VAL(59), .PRESCALE(1)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  bcd_mod_counter #(.MAX_VAL(59), .PRESCALE(3)) u_b (.clk(clk), .reset(reset), .bus(ifb));
  bcd_mod_counter #(.MAX_VAL(23), .PRESCALE(1)) u_c (.clk(clk), .reset(reset), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ev(input int t, input int u, input bit tc, input bit err);
    return {4'(t), 4'(u), tc, err};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed t=%0h u=%0h tc=%0b err=%0b, expected t=%0h u=%0h tc=%0b err=%0b",
             tag, obs[9:6], obs[5:2], obs[1], obs[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    n_checks = 0;
    n_errors = 0;
    {ifa.en, ifa.up_dn, ifa.clr, ifa.load, ifa.load_tens, ifa.load_units} = '0;
    {ifb.en, ifb.up_dn, ifb.clr, ifb.load, ifb.load_tens, ifb.load_units} = '0;
    {ifc.en, ifc.up_dn, ifc.clr, ifc.load, ifc.load_tens, ifc.load_units} = '0;
    reset = 1'b0;
    #22;
    chk("reset_a", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(0, 0, 0, 0));
    chk("reset_b", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 0, 0, 0));
    chk("reset_c", {ifc.tens, ifc.units, ifc.tc, ifc.load_err}, ev(0, 0, 0, 0));
    reset = 1'b1;
    tick();

    // Two full up periods on the mod-60 counter.
    ifa.up_dn = 1'b1;
    ifa.en    = 1'b1;
    v = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      v = (v + 1) % 60;
      chk($sformatf("up_a_%0d", i), {ifa.tens, ifa.units, ifa.tc, ifa.load_err},
          ev(v / 10, v % 10, v == 0, 0));
    end
    ifa.en = 1'b0;

    // Prescale 3 with en pattern 1,1,0,1.
    ifb.up_dn = 1'b1;
    ifb.en = 1'b1; tick(); chk("ps_en1", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 0, 0, 0));
    ifb.en = 1'b1; tick(); chk("ps_en2", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 0, 0, 0));
    ifb.en = 1'b0; tick(); chk("ps_hold", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 0, 0, 0));
    ifb.en = 1'b1; tick(); chk("ps_step1", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 1, 0, 0));
    tick(); chk("ps_w1", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 1, 0, 0));
    tick(); chk("ps_w2", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 1, 0, 0));
    tick(); chk("ps_step2", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 2, 0, 0));
    ifb.en = 1'b0;

    // Down-count on the mod-24 counter, then flip direction.
    ifc.up_dn = 1'b0;
    ifc.en    = 1'b1;
    tick(); chk("dn_wrap", {ifc.tens, ifc.units, ifc.tc, ifc.load_err}, ev(2, 3, 1, 0));
    tick(); chk("dn_22",   {ifc.tens, ifc.units, ifc.tc, ifc.load_err}, ev(2, 2, 0, 0));
    tick(); chk("dn_21",   {ifc.tens, ifc.units, ifc.tc, ifc.load_err}, ev(2, 1, 0, 0));
    tick(); chk("dn_20",   {ifc.tens, ifc.units, ifc.tc, ifc.load_err}, ev(2, 0, 0, 0));
    tick(); chk("dn_19",   {ifc.tens, ifc.units, ifc.tc, ifc.load_err}, ev(1, 9, 0, 0));
    ifc.up_dn = 1'b1;
    tick(); chk("flip_20", {ifc.tens, ifc.units, ifc.tc, ifc.load_err}, ev(2, 0, 0, 0));
    ifc.en = 1'b0;

    // Loads on the mod-60 counter (value 00, en low).
    ifa.load = 1'b1; ifa.load_tens = 4'd4; ifa.load_units = 4'd5;
    tick(); chk("load_45", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(4, 5, 0, 0));
    ifa.load_tens = 4'd6; ifa.load_units = 4'd0;
    tick(); chk("load_60_err", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(4, 5, 0, 1));
    ifa.load = 1'b0;
    tick(); chk("err_clear", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(4, 5, 0, 0));
    ifa.load = 1'b1; ifa.load_tens = 4'hA; ifa.load_units = 4'd1;
    tick(); chk("load_a1_err", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(4, 5, 0, 1));
    ifa.load_tens = 4'd5; ifa.load_units = 4'd9;
    tick(); chk("load_59", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(5, 9, 0, 0));
    ifa.load_tens = 4'd3; ifa.load_units = 4'd7;
    tick(); chk("load_37", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(3, 7, 0, 0));
    ifa.clr = 1'b1; ifa.load_tens = 4'd4; ifa.load_units = 4'd5;
    tick(); chk("clr_over_load", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(0, 0, 0, 0));
    ifa.clr = 1'b0; ifa.load_tens = 4'd5; ifa.load_units = 4'd9;
    tick(); chk("load_59b", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(5, 9, 0, 0));
    ifa.en = 1'b1; ifa.load_tens = 4'd1; ifa.load_units = 4'd2;
    tick(); chk("load_over_wrap", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(1, 2, 0, 0));
    ifa.load = 1'b0;
    tick(); chk("after_load_13", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(1, 3, 0, 0));

    // Asynchronous reset mid-count on the prescaled counter at 58.
    ifb.load = 1'b1; ifb.load_tens = 4'd5; ifb.load_units = 4'd8;
    tick(); chk("load_58", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(5, 8, 0, 0));
    ifb.load = 1'b0; ifb.en = 1'b1;
    tick(); chk("pre_rst_58", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(5, 8, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_b", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 0, 0, 0));
    chk("async_rst_a", {ifa.tens, ifa.units, ifa.tc, ifa.load_err}, ev(0, 0, 0, 0));
    reset = 1'b1;
    tick(); chk("rel_1", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 0, 0, 0));
    tick(); chk("rel_2", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 0, 0, 0));
    tick(); chk("rel_3", {ifb.tens, ifb.units, ifb.tc, ifb.load_err}, ev(0, 1, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised two-digit BCD modulo counter, successor to the fixed mod-60 seconds timer. Counts up or down through 0..MAX_VAL in packed BCD (tens, units), with count enable, built-in tick prescaler, synchronous clear and parallel load, and a terminal-count pulse for cascading into the next stage, for example seconds into minutes. Sits in the clock/timekeeping path between the tick generator and the display decoder.

## Interface
- MAX_VAL, 59: terminal value, decimal, legal range 1..99; counter wraps after MAX_VAL.
- PRESCALE, 1: enabled clk cycles per count step, range 1..65536; 1 means every enabled cycle.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset; clears all state while low.
- en  in  1  count enable; the prescaler advances only when high.
- up_dn  in  1  direction: 1 = up, 0 = down; sampled on each step.
- clr  in  1  synchronous clear to 0; highest synchronous priority.
- load  in  1  synchronous parallel load of load_tens:load_units.
- load_tens  in  4  BCD tens digit for load.
- load_units  in  4  BCD units digit for load.
- tens  out  4  BCD tens digit, registered.
- units  out  4  BCD units digit, registered.
- tc  out  1  one-cycle terminal-count pulse on wrap, registered.
- load_err  out  1  one-cycle pulse: load rejected, registered.

## Operation
- Reset low: tens=0, units=0, tc=0, load_err=0, prescaler=0, all immediately and asynchronously. State holds until the first rising edge after reset goes high.
- Priority per edge: clr > load > step. Lower-priority actions in the same cycle are discarded.
- clr: value becomes 0 and prescaler becomes 0. tc=0, load_err=0. Ignores en.
- load is valid only if load_tens≤9, load_units≤9 and 10·tens+units ≤ MAX_VAL.
  - Valid load: value takes the load value and the prescaler becomes 0. No tc.
  - Invalid load: value and prescaler are unchanged and load_err pulses. The invalid load does not count as a step.
- Prescaler: when en=1 it increments. A step occurs on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0. When en=0 the prescaler holds and value holds.
- Up step:
  - units<9 and value≠MAX_VAL: units+1.
  - units=9: units=0, tens+1.
  - value=MAX_VAL: value becomes 0 and tc pulses.
- Down step:
  - units>0: units−1.
  - units=0 and tens>0: units=9, tens−1.
  - value=0: value becomes MAX_VAL (tens=MAX_VAL/10, units=MAX_VAL%10) and tc pulses.
- Direction change takes effect on the next step with no extra latency. The prescaler is not reset.
- Defensive rule: if the held value is ever outside 0..MAX_VAL or a digit exceeds 9, the next step forces 0 with no tc.
- Digits are always legal BCD (0..9) at the outputs. Binary intermediate values never appear.

## Timing
- All outputs are registered. Updates occur on the rising clk edge only, except reset.
- Step latency: value changes on the edge that completes the PRESCALE-th enabled cycle.
- tc is high for exactly the one cycle in which the wrapped value (0 when counting up, MAX_VAL when counting down) is first visible, then returns to 0. It never stays high for two consecutive cycles unless PRESCALE=1 and MAX_VAL wraps every cycle, which is impossible since MAX_VAL≥1.
- load_err is high for exactly the cycle after the rejected load edge.
- clr or load in the same cycle as a wrapping step: no tc.
- Reset asserted mid-count: outputs go to 0 without waiting for clk. Any pending tc or load_err is cancelled.

## Test plan
- Reset then up-count, MAX_VAL=59, PRESCALE=1, en=1: sequence 00,01,..,09,10,..,59,00. tc=1 only with 00 after 59. Repeat for 2 full periods.
- PRESCALE=3, en toggling 1,1,0,1: the first step lands on the third enabled cycle. Value holds while en=0 and the prescaler does not advance.
- Down-count from 00, MAX_VAL=23: next value 23 with tc=1, then 22,21,20,19. Flip up_dn mid-run: 19→20 on the next step.
- Load 4:5 with MAX_VAL=59: value becomes 45. Load 6:0 or A:1: value unchanged, load_err pulses one cycle.
- clr and load together at value 37: result 00. load and step together: the load value wins and there is no tc.
- Drop reset low mid-count at 58, asynchronously between edges: tens=0, units=0, tc=0 immediately. Release: counting resumes from 00 with a full prescale interval.
